uda1341_l3_ctrl: RTL and testbench

- Configuration controller for the UDA1341TS codec's L3 control bus (L3MODE, L3CLOCK, L3DATA).
- After reset, waits a power-up delay, then plays a fixed init sequence of register writes.
- Then serves runtime single-word writes (e.g. volume) through a req/ack handshake.
- Sits beside the I2S ws/bck generator in audio_mixer; `init_done` gates audio datapath enable.

---
 rtl/uda1341_l3_pkg.sv | 44 ++++
 rtl/uda1341_l3_init_rom.sv | 15 +
 rtl/uda1341_l3_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uda1341_l3_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uda1341_l3_pkg.sv
// Shared definitions for the UDA1341TS L3 control-bus controller:
// device address, register select codes, FSM state encoding and the
// power-up init table.
package uda1341_l3_pkg;

  localparam logic [5:0] L3_DEV_ADDR = 6'b000101;

  localparam logic [1:0] SEL_DATA0  = 2'b00;
  localparam logic [1:0] SEL_DATA1  = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_IDLE,
    ST_LOAD,
    ST_ADDR_SETUP,
    ST_ADDR_BITS,
    ST_MODE_GAP,
    ST_DATA_BITS,
    ST_END_GAP
  } l3_state_t;

  // Init table entries, {sel, data}
  localparam logic [9:0] INIT_W0 = {SEL_STATUS, 8'h40};  // codec reset asserted
  localparam logic [9:0] INIT_W1 = {SEL_STATUS, 8'h20};  // reset released, 256fs, I2S
  localparam logic [9:0] INIT_W2 = {SEL_STATUS, 8'h83};  // status1: ADC+DAC power on
  localparam logic [9:0] INIT_W3 = {SEL_DATA0,  8'h00};  // volume 0 dB

  // Reserved select 11 is addressed as STATUS.
  function automatic logic [7:0] l3_addr_byte(input logic [1:0] sel);
    return {L3_DEV_ADDR, (sel == 2'b11) ? SEL_STATUS : sel};
  endfunction

  function automatic logic [9:0] init_entry(input int unsigned idx);
    case (idx)
      0:       return INIT_W0;
      1:       return INIT_W1;
      2:       return INIT_W2;
      3:       return INIT_W3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/uda1341_l3_init_rom.sv
// Combinational init-sequence lookup.
//   ptr  : init table index
//   word : {sel[1:0], data[7:0]} for that entry
module uda1341_l3_init_rom
  import uda1341_l3_pkg::*;
#(
  parameter int unsigned PTR_W = 2
) (
  input  logic [PTR_W-1:0] ptr,
  output logic [9:0]       word
);

  always_comb word = init_entry(32'(ptr));

endmodule

// File: rtl/uda1341_l3_ctrl.sv
// UDA1341TS L3 bus configuration controller. After reset waits PWR_WAIT
// cycles, plays the init table, then serves single register writes.
//   clk, nRst          : system clock, async active-low reset
//   wr_req/wr_ack      : runtime write handshake (ack = 1-cycle accept pulse)
//   wr_sel, wr_data    : target register and data byte, latched on ack
//   busy               : low only while idle
//   init_done          : sticky once the last init word has been sent
//   l3_mode/clock/data : L3 bus, bytes sent LSB first
module uda1341_l3_ctrl
  import uda1341_l3_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 24,
  parameter int unsigned GAP_CYCLES = 48,
  parameter int unsigned PWR_WAIT   = 4800,
  parameter int unsigned INIT_LEN   = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       wr_req,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       init_done,
  output logic       l3_mode,
  output logic       l3_clock,
  output logic       l3_data
);

  localparam int unsigned CNT_MAX = (PWR_WAIT > GAP_CYCLES)
                                    ? ((PWR_WAIT > CLK_DIV) ? PWR_WAIT : CLK_DIV)
                                    : ((GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_WAIT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(INIT_LEN - 1);

  l3_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             phase, phase_nxt;      // 0 = low half, 1 = high half
  logic [7:0]       addr_sr, addr_sr_nxt;
  logic [7:0]       data_sr, data_sr_nxt;
  logic [PTR_W-1:0] init_ptr, init_ptr_nxt;
  logic             init_done_nxt;
  logic [1:0]       sel_q, sel_q_nxt;
  logic [7:0]       data_q, data_q_nxt;
  logic             mode_nxt, clock_nxt, data_nxt;
  logic [9:0]       rom_word;
  logic [1:0]       load_sel;
  logic [7:0]       load_data;

  uda1341_l3_init_rom #(.PTR_W(PTR_W)) u_rom (
    .ptr  (init_ptr),
    .word (rom_word)
  );

  // Init words take precedence until the table has been played out.
  assign load_sel  = init_done ? sel_q  : rom_word[9:8];
  assign load_data = init_done ? data_q : rom_word[7:0];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= ST_PWR;
      cnt       <= '0;
      bit_idx   <= '0;
      phase     <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      init_ptr  <= '0;
      init_done <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      l3_mode   <= 1'b1;
      l3_clock  <= 1'b1;
      l3_data   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      phase     <= phase_nxt;
      addr_sr   <= addr_sr_nxt;
      data_sr   <= data_sr_nxt;
      init_ptr  <= init_ptr_nxt;
      init_done <= init_done_nxt;
      sel_q     <= sel_q_nxt;
      data_q    <= data_q_nxt;
      l3_mode   <= mode_nxt;
      l3_clock  <= clock_nxt;
      l3_data   <= data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    phase_nxt     = phase;
    addr_sr_nxt   = addr_sr;
    data_sr_nxt   = data_sr;
    init_ptr_nxt  = init_ptr;
    init_done_nxt = init_done;
    sel_q_nxt     = sel_q;
    data_q_nxt    = data_q;
    mode_nxt      = l3_mode;
    clock_nxt     = l3_clock;
    data_nxt      = l3_data;
    wr_ack        = 1'b0;
    busy          = 1'b1;

    case (state)
      ST_PWR: begin
        if (cnt == PWR_LAST) begin
          cnt_nxt      = '0;
          init_ptr_nxt = '0;
          state_nxt    = ST_LOAD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        busy = 1'b0;
        if (!init_done) begin
          state_nxt = ST_LOAD;
        end else if (wr_req) begin
          wr_ack     = 1'b1;
          sel_q_nxt  = wr_sel;
          data_q_nxt = wr_data;
          state_nxt  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        addr_sr_nxt = l3_addr_byte(load_sel);
        data_sr_nxt = load_data;
        mode_nxt    = 1'b0;
        cnt_nxt     = '0;
        state_nxt   = ST_ADDR_SETUP;
      end

      ST_ADDR_SETUP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          phase_nxt   = 1'b0;
          clock_nxt   = 1'b0;
          data_nxt    = addr_sr[0];
          state_nxt   = ST_ADDR_BITS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      // Both byte phases share the bit engine; the active shift register
      // moves one place when a high half ends and another bit follows.
      ST_ADDR_BITS, ST_DATA_BITS: begin
        if (cnt != HALF_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (!phase) begin
            clock_nxt = 1'b1;
            phase_nxt = 1'b1;
          end else if (bit_idx == 3'd7) begin
            if (state == ST_ADDR_BITS) begin
              mode_nxt  = 1'b1;
              state_nxt = ST_MODE_GAP;
            end else begin
              data_nxt  = 1'b0;
              state_nxt = ST_END_GAP;
            end
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            phase_nxt   = 1'b0;
            clock_nxt   = 1'b0;
            if (state == ST_ADDR_BITS) begin
              data_nxt    = addr_sr[1];
              addr_sr_nxt = addr_sr >> 1;
            end else begin
              data_nxt    = data_sr[1];
              data_sr_nxt = data_sr >> 1;
            end
          end
        end
      end

      ST_MODE_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          phase_nxt   = 1'b0;
          clock_nxt   = 1'b0;
          data_nxt    = data_sr[0];
          state_nxt   = ST_DATA_BITS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_END_GAP: begin
        data_nxt = 1'b0;
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (!init_done && init_ptr != PTR_LAST) begin
            init_ptr_nxt = init_ptr + 1'b1;
            state_nxt    = ST_LOAD;
          end else begin
            if (!init_done) init_done_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: state_nxt = ST_PWR;
    endcase
  end

endmodule

// File: tb/tb_uda1341_l3_ctrl.sv
// Scoreboard bench for uda1341_l3_ctrl with short timing parameters.
// Stimulus pushes expected {addr,data} words; a bus monitor decodes L3
// traffic on l3_clock rising edges and pops/compares each complete word.
module tb_uda1341_l3_ctrl;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP     = 4;
  localparam int unsigned PWR     = 10;
  localparam int          XFER    = 77;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       wr_req = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack, busy, init_done, l3_mode, l3_clock, l3_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] exp_q[$];

  uda1341_l3_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP),
    .PWR_WAIT   (PWR),
    .INIT_LEN   (4)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .wr_req    (wr_req),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .init_done (init_done),
    .l3_mode   (l3_mode),
    .l3_clock  (l3_clock),
    .l3_data   (l3_data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'h14;
      2'b01:   return 8'h15;
      default: return 8'h16;
    endcase
  endfunction

  // Bus monitor
  initial begin
    logic       prev_clk, prev_mode;
    logic [7:0] addr_v, data_v;
    int         na, nd;
    prev_clk = 1'b1; prev_mode = 1'b1; addr_v = '0; data_v = '0; na = 0; nd = 0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        prev_clk = 1'b1; prev_mode = 1'b1; na = 0; nd = 0;
      end else begin
        if (l3_mode !== prev_mode)
          check("mode_change_while_clock_high", {30'd0, prev_clk, l3_clock}, 32'd3);
        if (!prev_clk && l3_clock) begin
          if (!l3_mode) begin
            addr_v = {l3_data, addr_v[7:1]};
            na++;
          end else begin
            data_v = {l3_data, data_v[7:1]};
            nd++;
            if (nd == 8) begin
              check("addr_bit_count", na, 8);
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", {addr_v, data_v});
              end else begin
                check("l3_word", {addr_v, data_v}, exp_q.pop_front());
              end
              na = 0;
              nd = 0;
            end
          end
        end
        prev_clk  = l3_clock;
        prev_mode = l3_mode;
      end
    end
  end

  task automatic push_init();
    exp_q.push_back(16'h1640);
    exp_q.push_back(16'h1620);
    exp_q.push_back(16'h1683);
    exp_q.push_back(16'h1400);
  endtask

  // Runs from reset release to init_done; optionally holds a DATA1 write
  // request from cycle 20 and follows it through ack and completion.
  task automatic init_phase(input bit with_req);
    int k, j;
    bit pwr_bad, early_ack;
    int mode_fall;
    pwr_bad = 0; early_ack = 0; mode_fall = 0;
    for (k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (with_req && k == 20) begin
        wr_sel = 2'b01; wr_data = 8'hA5; wr_req = 1'b1;
        #1;
      end
      if (wr_ack && !init_done) early_ack = 1;
      if (k <= int'(PWR) && (!l3_mode || !l3_clock || !busy)) pwr_bad = 1;
      if (mode_fall == 0 && !l3_mode) mode_fall = k;
      if (init_done) break;
    end
    check("pwr_wait_hold", {31'd0, pwr_bad}, 0);
    check("first_mode_fall_cycle", mode_fall, PWR + 1);
    check("init_done_cycle", k, PWR + 4 * XFER);
    check("no_ack_before_init", {31'd0, early_ack}, 0);
    if (with_req) begin
      check("ack_at_init_done", {31'd0, wr_ack}, 1);
      exp_q.push_back(16'h15A5);
      @(posedge clk);
      #1 wr_req = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", {31'd0, wr_ack}, 0);
      j = 1;
      while (busy && j < 400) begin
        @(negedge clk);
        j++;
      end
      check("busy_low_after_xfer", j, XFER + 1);
    end
  endtask

  task automatic request(input logic [1:0] sel, input logic [7:0] d, output int t_ack);
    int waited;
    wr_sel = sel; wr_data = d; wr_req = 1'b1;
    #1;
    waited = 0;
    while (!wr_ack && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("ack_seen", {31'd0, wr_ack}, 1);
    check("idle_at_ack", {31'd0, busy}, 0);
    t_ack = cyc;
    exp_q.push_back({exp_addr(sel), d});
    @(posedge clk);
    #1 wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 0);
  endtask

  initial begin
    int  tA, tB, tC, n;
    bit  pulse_ack, bus_active;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_l3_mode", {31'd0, l3_mode}, 1);
    check("rst_l3_clock", {31'd0, l3_clock}, 1);
    check("rst_l3_data", {31'd0, l3_data}, 0);
    check("rst_wr_ack", {31'd0, wr_ack}, 0);
    check("rst_init_done", {31'd0, init_done}, 0);
    check("rst_busy", {31'd0, busy}, 1);

    // Power-up wait, init sequence, request held off until init_done
    nRst = 1'b1;
    push_init();
    init_phase(1'b1);

    // Back-to-back: second request raised mid-transfer
    @(negedge clk);
    request(2'b00, 8'h3C, tA);
    repeat (20) @(negedge clk);
    request(2'b11, 8'h81, tB);
    check("b2b_ack_delay", tB - tA, XFER + 1);
    wait_idle();

    // Single-cycle request pulse during a transfer is never accepted
    @(negedge clk);
    request(2'b00, 8'h7E, tC);
    repeat (10) @(negedge clk);
    wr_sel = 2'b01; wr_data = 8'h11; wr_req = 1'b1;
    pulse_ack = 0;
    #1 if (wr_ack) pulse_ack = 1;
    @(negedge clk);
    wr_req = 1'b0;
    wait_idle();
    bus_active = 0;
    for (n = 0; n < 150; n++) begin
      @(negedge clk);
      if (wr_ack) pulse_ack = 1;
      if (!l3_mode || !l3_clock || busy) bus_active = 1;
    end
    check("pulse_never_acked", {31'd0, pulse_ack}, 0);
    check("bus_idle_after_pulse", {31'd0, bus_active}, 0);
    check("queue_drained", exp_q.size(), 0);

    // Reset asserted in the middle of DATA_BITS
    @(negedge clk);
    request(2'b01, 8'h5A, tC);
    void'(exp_q.pop_back());   // this word is aborted by reset
    n = 0;
    while (!l3_mode && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (l3_clock && n < 200) begin @(negedge clk); n++; end
    check("reached_data_bits", {31'd0, l3_clock}, 0);
    repeat (5) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("midrst_l3_mode", {31'd0, l3_mode}, 1);
    check("midrst_l3_clock", {31'd0, l3_clock}, 1);
    check("midrst_l3_data", {31'd0, l3_data}, 0);
    check("midrst_init_done", {31'd0, init_done}, 0);
    check("midrst_busy", {31'd0, busy}, 1);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    push_init();
    init_phase(1'b0);
    repeat (5) @(negedge clk);
    check("replay_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
